// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : Frame-level UART transmitter. Sequences start, data (LSB
//               first), optional parity and one or two stop bits. Bit
//               boundaries are taken from an external baud timer's alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int BBITS = 16,
    parameter int DBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DBITS-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [BBITS-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic             tim_rst,
    output logic             tim_enable,
    output logic [BBITS-1:0] tim_cnt_val,
    input  logic             tim_alarm
);

    localparam int                 c_IDX_W    = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DBITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DBITS-1:0]   r_shreg;
    logic [DBITS-1:0]   w_shreg_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic               r_stop_cnt;
    logic               w_stop_nxt;
    logic               r_parity;
    logic               r_parity_en;
    logic               r_two_stop;
    logic               r_tx;
    logic               r_busy;
    logic               r_tx_ready;
    logic               r_tim_enable;
    logic [BBITS-1:0]   r_cnt_val;
    logic               w_accept;
    logic               w_clear;
    logic               w_done;
    logic               w_tx_nxt;

    assign w_accept = (r_state == ST_IDLE) && tx_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_idx_nxt   = r_idx;
        w_stop_nxt  = r_stop_cnt;
        w_clear     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_clear     = 1'b1;
                    w_shreg_nxt = tx_data;
                    w_idx_nxt   = '0;
                    w_stop_nxt  = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (tim_alarm) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tim_alarm) begin
                    w_shreg_nxt = {1'b0, r_shreg[DBITS-1:1]};
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = r_parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (tim_alarm) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tim_alarm) begin
                    if (r_two_stop && !r_stop_cnt) begin
                        w_stop_nxt = 1'b1;
                    end else begin
                        w_stop_nxt  = 1'b0;
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level is registered, so it is derived from the state being entered.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shreg_nxt[0];
            ST_PARITY: w_tx_nxt = r_parity;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_idx        <= '0;
            r_stop_cnt   <= 1'b0;
            r_parity     <= 1'b0;
            r_parity_en  <= 1'b0;
            r_two_stop   <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_tx_ready   <= 1'b1;
            r_tim_enable <= 1'b0;
            r_cnt_val    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_idx        <= w_idx_nxt;
            r_stop_cnt   <= w_stop_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_tx_ready   <= (w_state_nxt == ST_IDLE);
            r_tim_enable <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_cnt_val   <= baud_div;
                r_parity_en <= parity_en;
                r_two_stop  <= two_stop;
                r_parity    <= (^tx_data) ^ parity_odd;
            end
        end
    end

    // done is qualified by the live alarm so it lands in the final stop-bit cycle.
    assign done        = w_done & ~rst;
    assign tim_rst     = rst | w_clear;
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign tx_ready    = r_tx_ready;
    assign tim_enable  = r_tim_enable;
    assign tim_cnt_val = r_cnt_val;

endmodule
`default_nettype wire
